// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame width and the baud divisor math
// used by both the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        longint den;
        longint q;
        den = longint'(baud) * longint'(oversample);
        q   = (longint'(clk_hz) + den / 2) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick at OVERSAMPLE times the baud rate.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic Clock,
    input  logic Reset,
    output logic tick
);

    localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, one-cycle byte and
// framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Rx_Ready,
    output logic                 Frame_Error,
    output logic                 Busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta, rx_s;
    state_t               state, state_next;
    logic [SW-1:0]        s_cnt, s_cnt_next;
    logic [2:0]           b_cnt, b_cnt_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 ready_next, ferr_next;

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .Clock(Clock),
        .Reset(Reset),
        .tick (tick)
    );

    // Synchronizer presets to the idle level so reset never looks like a start bit.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            s_cnt <= '0;
            b_cnt <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            s_cnt <= s_cnt_next;
            b_cnt <= b_cnt_next;
            shift <= shift_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        b_cnt_next = b_cnt;
        shift_next = shift;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        s_cnt_next = '0;
                    end
                end
                START: begin
                    if (s_cnt == S_MID) begin
                        state_next = rx_s ? IDLE : DATA;
                        s_cnt_next = '0;
                        b_cnt_next = '0;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (s_cnt == S_LAST) begin
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        s_cnt_next = '0;
                        if (b_cnt == B_LAST)
                            state_next = STOP;
                        else
                            b_cnt_next = b_cnt + 1'b1;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_next = '0;
                        // Leaving at mid-stop lets a back-to-back start edge be caught.
                        state_next = rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_next = 1'b0;
        ferr_next  = 1'b0;
        if (tick && state == STOP && s_cnt == S_LAST) begin
            ready_next = rx_s;
            ferr_next  = !rx_s;
        end
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Data        <= '0;
            Rx_Ready    <= 1'b0;
            Frame_Error <= 1'b0;
        end else begin
            if (ready_next)
                Data <= shift;
            Rx_Ready    <= ready_next;
            Frame_Error <= ferr_next;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are driven
// and popped when Rx_Ready fires.
module tb_uart_rx;

    localparam int BIT = 160;  // clocks per bit at DIV=10, 16x oversampling

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Rx;
    logic [7:0] Data;
    logic       Rx_Ready;
    logic       Frame_Error;
    logic       Busy;

    always #5 Clock = ~Clock;

    uart_rx #(
        .CLK_HZ    (1_600_000),
        .BAUD      (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Rx         (Rx),
        .Data       (Data),
        .Rx_Ready   (Rx_Ready),
        .Frame_Error(Frame_Error),
        .Busy       (Busy)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    longint     cycle = 0;
    logic [7:0] exp_q[$];
    int         ferr_pending = 0;
    longint     ready_times[$];
    longint     frame_start = 0;
    logic       prev_pulse = 1'b0;

    always @(posedge Clock) cycle <= cycle + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        check($sformatf("%s=%0d want %0d..%0d", tag, got, lo, hi),
              int'(got >= lo && got <= hi), 1);
    endtask

    // Monitor: every pulse must be expected, exclusive and exactly one cycle wide.
    always @(negedge Clock) begin
        if (Rx_Ready || Frame_Error) begin
            check("pulse_excl", int'(Rx_Ready & Frame_Error), 0);
            check("pulse_width", int'(prev_pulse), 0);
        end
        if (Rx_Ready) begin
            check("ready_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                check("rx_data", int'(Data), int'(exp_q.pop_front()));
            ready_times.push_back(cycle);
        end
        if (Frame_Error) begin
            check("ferr_expected", int'(ferr_pending != 0), 1);
            if (ferr_pending != 0)
                ferr_pending--;
        end
        prev_pulse = Rx_Ready | Frame_Error;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_cyc);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        if (stop_bit)
            exp_q.push_back(b);
        else
            ferr_pending++;
        frame_start = cycle;
        for (int i = 0; i < 10; i++) begin
            Rx = frame[i];
            repeat (bit_cyc) @(negedge Clock);
        end
    endtask

    task automatic idle_bits(input int n);
        Rx = 1'b1;
        repeat (n * BIT) @(negedge Clock);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ferr_pending != 0) && n < 4 * BIT) begin
            @(negedge Clock);
            n++;
        end
        check(tag, exp_q.size() + ferr_pending, 0);
    endtask

    initial begin
        logic [9:0] frame;

        Reset = 1'b0;
        Rx    = 1'b1;
        repeat (5) @(negedge Clock);
        check("rst_data", int'(Data), 8'h00);
        check("rst_ready", int'(Rx_Ready), 0);
        check("rst_ferr", int'(Frame_Error), 0);
        check("rst_busy", int'(Busy), 0);
        Reset = 1'b1;
        idle_bits(2);

        // Single frame; latency runs from the start edge to the mid-stop sample (9.5 bits)
        ready_times.delete();
        send_byte(8'hA5, 1'b1, BIT);
        drain("a5_drain");
        check("a5_count", ready_times.size(), 1);
        if (ready_times.size() == 1)
            check_range("a5_latency", int'(ready_times[0] - frame_start), 1520, 1536);
        idle_bits(1);

        // 40-cycle low glitch must be rejected at the mid-start check
        Rx = 1'b0;
        repeat (30) @(negedge Clock);
        check("glitch_busy", int'(Busy), 1);
        repeat (10) @(negedge Clock);
        idle_bits(2);
        check("glitch_idle", int'(Busy), 0);
        check("glitch_data", int'(Data), 8'hA5);
        check("glitch_no_ready", ready_times.size(), 1);

        // Bad stop bit, then a 5-bit break, then a good frame
        send_byte(8'h3C, 1'b0, BIT);
        repeat (5 * BIT) @(negedge Clock);
        check("break_busy", int'(Busy), 1);
        idle_bits(2);
        check("ferr_seen", ferr_pending, 0);
        check("ferr_data", int'(Data), 8'hA5);
        check("break_idle", int'(Busy), 0);
        send_byte(8'h81, 1'b1, BIT);
        drain("x81_drain");
        check("x81_data", int'(Data), 8'h81);
        idle_bits(1);

        // Back-to-back frames with no idle gap
        ready_times.delete();
        send_byte(8'h00, 1'b1, BIT);
        send_byte(8'hFF, 1'b1, BIT);
        drain("b2b_drain");
        check("b2b_count", ready_times.size(), 2);
        if (ready_times.size() == 2)
            check_range("b2b_spacing", int'(ready_times[1] - ready_times[0]), 1590, 1610);
        idle_bits(1);

        // Reset in the middle of bit 4 of 0x55
        ready_times.delete();
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 5; i++) begin
            Rx = frame[i];
            repeat (BIT) @(negedge Clock);
        end
        Rx = frame[5];
        repeat (BIT / 2) @(negedge Clock);
        check("pre_rst_busy", int'(Busy), 1);
        Reset = 1'b0;
        #1;
        check("mid_rst_data", int'(Data), 8'h00);
        check("mid_rst_busy", int'(Busy), 0);
        check("mid_rst_ready", int'(Rx_Ready), 0);
        check("mid_rst_ferr", int'(Frame_Error), 0);
        Rx = 1'b1;
        repeat (20) @(negedge Clock);
        Reset = 1'b1;
        idle_bits(2);
        check("post_rst_data", int'(Data), 8'h00);
        send_byte(8'h7E, 1'b1, BIT);
        drain("x7e_drain");
        check("x7e_count", ready_times.size(), 1);
        idle_bits(1);

        // Sender baud off by about +3% and -3%
        send_byte(8'hC3, 1'b1, 165);
        idle_bits(2);
        drain("slow_drain");
        check("slow_data", int'(Data), 8'hC3);
        send_byte(8'h3C, 1'b1, 155);
        idle_bits(2);
        drain("fast_drain");
        check("fast_data", int'(Data), 8'h3C);
        send_byte(8'hC3, 1'b1, 155);
        idle_bits(2);
        drain("fast2_drain");
        check("fast2_data", int'(Data), 8'hC3);
        check("final_ferr", ferr_pending, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
